// File: rtl/decimator_pkg.sv
// Shared definitions for the multi-channel decimator and its config decoder.
package decimator_pkg;

  localparam int DEC_MODE_W = 2;

  typedef enum logic [DEC_MODE_W-1:0] {
    DEC_MODE_DECIM = 2'd0,
    DEC_MODE_AVG   = 2'd1,
    DEC_MODE_PEAK  = 2'd2
  } dec_mode_e;

  // Raw mode field to enum; the unused encoding 3 behaves as averaging.
  function automatic dec_mode_e decode_mode(input logic [DEC_MODE_W-1:0] raw);
    dec_mode_e m;
    case (raw)
      2'd0:    m = DEC_MODE_DECIM;
      2'd1:    m = DEC_MODE_AVG;
      2'd2:    m = DEC_MODE_PEAK;
      default: m = DEC_MODE_AVG;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decimator_channel.sv
// One channel of the decimator: accumulator, running min/max and output mux.
// Block boundaries, k and mode are supplied by the shared control in the top.
module decimator_channel
  import decimator_pkg::*;
#(
  parameter int BITS_ADC  = 8,
  parameter int BITS_ACUM = 16,
  parameter int K_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITS_ADC-1:0] i_sample,
  input  logic                i_accept,
  input  logic                i_start,
  input  logic                i_last,
  input  logic [K_W-1:0]      i_k,
  input  dec_mode_e           i_mode,
  output logic [BITS_ADC-1:0] o_sample,
  output logic [BITS_ADC-1:0] o_max
);

  logic [BITS_ACUM-1:0] r_acc;
  logic [BITS_ADC-1:0]  r_min;
  logic [BITS_ADC-1:0]  r_max;
  logic [BITS_ADC-1:0]  r_out;
  logic [BITS_ADC-1:0]  r_out_max;

  logic [BITS_ACUM-1:0] w_acc_nxt;
  logic [BITS_ADC-1:0]  w_min_nxt;
  logic [BITS_ADC-1:0]  w_max_nxt;
  logic [BITS_ADC-1:0]  w_res;
  logic [BITS_ADC-1:0]  w_res_max;

  // Next accumulator/min/max including the sample arriving this cycle.
  // In decimate mode the accumulator simply keeps the first sample of the block.
  always_comb begin
    w_acc_nxt = r_acc;
    w_min_nxt = r_min;
    w_max_nxt = r_max;
    if (i_start) begin
      w_acc_nxt = BITS_ACUM'(i_sample);
      w_min_nxt = i_sample;
      w_max_nxt = i_sample;
    end else begin
      if (i_mode == DEC_MODE_AVG) begin
        w_acc_nxt = r_acc + BITS_ACUM'(i_sample);
      end else begin
        w_acc_nxt = r_acc;
      end
      w_min_nxt = (i_sample < r_min) ? i_sample : r_min;
      w_max_nxt = (i_sample > r_max) ? i_sample : r_max;
    end
  end

  // Result selection for the block that completes this cycle.
  always_comb begin
    w_res     = BITS_ADC'(w_acc_nxt);
    w_res_max = BITS_ADC'(w_acc_nxt);
    case (i_mode)
      DEC_MODE_DECIM: begin
        w_res     = BITS_ADC'(w_acc_nxt);
        w_res_max = BITS_ADC'(w_acc_nxt);
      end
      DEC_MODE_PEAK: begin
        w_res     = w_min_nxt;
        w_res_max = w_max_nxt;
      end
      default: begin
        w_res     = BITS_ADC'(w_acc_nxt >> i_k);
        w_res_max = BITS_ADC'(w_acc_nxt >> i_k);
      end
    endcase
  end

  // Running state advances only on accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_min <= '0;
      r_max <= '0;
    end else if (i_accept) begin
      r_acc <= w_acc_nxt;
      r_min <= w_min_nxt;
      r_max <= w_max_nxt;
    end else begin
      r_acc <= r_acc;
      r_min <= r_min;
      r_max <= r_max;
    end
  end

  // Output registers update at block end and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out     <= '0;
      r_out_max <= '0;
    end else if (i_accept && i_last) begin
      r_out     <= w_res;
      r_out_max <= w_res_max;
    end else begin
      r_out     <= r_out;
      r_out_max <= r_out_max;
    end
  end

  assign o_sample = r_out;
  assign o_max    = r_out_max;

endmodule

// File: rtl/multi_channel_decimator.sv
// Multi-channel decimator: shared block counter and config latch driving
// CHANNELS identical datapaths that decimate, average or track min/max.
module multi_channel_decimator
  import decimator_pkg::*;
#(
  parameter int BITS_ADC  = 8,
  parameter int BITS_ACUM = 16,
  parameter int CHANNELS  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(BITS_ACUM-BITS_ADC+1)-1:0] k,
  input  logic [1:0]                             mode,
  input  logic [CHANNELS*BITS_ADC-1:0]           sample_in,
  input  logic                                   rdy_in,
  output logic [CHANNELS*BITS_ADC-1:0]           sample_out,
  output logic [CHANNELS*BITS_ADC-1:0]           sample_max,
  output logic                                   rdy_out
);

  localparam int BIT_DIFF = BITS_ACUM - BITS_ADC;
  localparam int K_W      = $clog2(BIT_DIFF + 1);
  localparam int CNT_W    = BIT_DIFF + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [K_W-1:0]   r_k;
  dec_mode_e        r_mode;
  logic             r_rdy_out;

  logic             w_start;
  logic             w_last;
  logic [K_W-1:0]   w_k_clamp;
  logic [K_W-1:0]   w_k_eff;
  dec_mode_e        w_mode_eff;
  logic [CNT_W-1:0] w_df_m1;

  // Block control: a block starts on a sample with cnt==0, where the live
  // k/mode take effect immediately; later samples use the latched copies.
  always_comb begin
    w_start    = rdy_in && (r_cnt == CNT_W'(0));
    w_k_clamp  = (k > K_W'(BIT_DIFF)) ? K_W'(BIT_DIFF) : k;
    w_k_eff    = r_k;
    w_mode_eff = r_mode;
    if (w_start) begin
      w_k_eff    = w_k_clamp;
      w_mode_eff = decode_mode(mode);
    end else begin
      w_k_eff    = r_k;
      w_mode_eff = r_mode;
    end
    w_df_m1 = (CNT_W'(1) << w_k_eff) - CNT_W'(1);
    w_last  = rdy_in && (r_cnt == w_df_m1);
  end

  // Sample counter, config latch and output strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_k       <= '0;
      r_mode    <= DEC_MODE_AVG;
      r_rdy_out <= 1'b0;
    end else begin
      r_rdy_out <= w_last;
      if (rdy_in) begin
        r_cnt <= w_last ? CNT_W'(0) : r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_start) begin
        r_k    <= w_k_clamp;
        r_mode <= w_mode_eff;
      end else begin
        r_k    <= r_k;
        r_mode <= r_mode;
      end
    end
  end

  assign rdy_out = r_rdy_out;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    decimator_channel #(
      .BITS_ADC (BITS_ADC),
      .BITS_ACUM(BITS_ACUM),
      .K_W      (K_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_sample(sample_in[c*BITS_ADC +: BITS_ADC]),
      .i_accept(rdy_in),
      .i_start (w_start),
      .i_last  (w_last),
      .i_k     (w_k_eff),
      .i_mode  (w_mode_eff),
      .o_sample(sample_out[c*BITS_ADC +: BITS_ADC]),
      .o_max   (sample_max[c*BITS_ADC +: BITS_ADC])
    );
  end

endmodule
